vec_capture: RTL

Synthesizable test-vector recorder: the writing end of the team's vector-file flow, whose testbenches read packed stimulus/expected words and apply them to a DUT. `vec_capture` samples packed words from a live DUT boundary, for example `{d0, d1, s, y}` of a mux, into an internal buffer. On request it plays the buffer out over a valid/ready port, so hardware runs can regenerate vector files. It sits beside the DUT in the `*_top` wrapper.

---
 rtl/vec_capture_pkg.sv | 6 +
 rtl/vec_capture_if.sv | 25 ++
 rtl/vec_capture_ram.sv | 20 ++
 rtl/vec_capture.sv | 72 +++++++
 4 files changed

// File: rtl/vec_capture_pkg.sv
// vec_capture_pkg: shared state type and default geometry for the vector recorder
package vec_capture_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, DUMP} vc_state_t;
  localparam int VC_WIDTH = 15;
  localparam int VC_DEPTH = 16;
endpackage

// File: rtl/vec_capture_if.sv
// vec_capture_if: control, sample and dump port bundle of the vector recorder
interface vec_capture_if import vec_capture_pkg::*; #(
  parameter int WIDTH = VC_WIDTH,
  parameter int DEPTH = VC_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) ();
  logic arm;
  logic stop;
  logic sample_valid;
  logic [WIDTH-1:0] sample_data;
  logic rd_valid;
  logic rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [ADDR_W:0] count;
  logic full;
  logic busy;
  modport master (
    output arm, stop, sample_valid, sample_data, rd_ready,
    input rd_valid, rd_data, count, full, busy
  );
  modport slave (
    input arm, stop, sample_valid, sample_data, rd_ready,
    output rd_valid, rd_data, count, full, busy
  );
endinterface

// File: rtl/vec_capture_ram.sv
// vec_capture_ram: reset-cleared buffer, synchronous write, asynchronous read
module vec_capture_ram import vec_capture_pkg::*; #(
  parameter int WIDTH = VC_WIDTH,
  parameter int DEPTH = VC_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mem <= '{default: '0};
    else if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/vec_capture.sv
// vec_capture: records sampled DUT words and dumps them over valid/ready; VEC_CAPTURE_DEDUP_EN drops repeated words
module vec_capture import vec_capture_pkg::*; #(
  parameter int WIDTH = VC_WIDTH,
  parameter int DEPTH = VC_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset_n,
  vec_capture_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  vc_state_t state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_wr;
  logic start, wr_en, rd_en, dup;
  assign start = state == IDLE && bus.arm;
  assign wr_en = state == CAPTURE && bus.sample_valid && !dup;
  assign rd_en = state == DUMP && bus.rd_ready;
  assign count_wr = count + CW'(wr_en);
  always_comb
    state_nx = state == IDLE ? (bus.arm ? CAPTURE : IDLE) :
               state == CAPTURE ? ((count_wr == CW'(DEPTH) || (bus.stop && count_wr != '0)) ? DUMP :
                                   bus.stop ? IDLE : CAPTURE) :
               (rd_en && count == CW'(1)) ? IDLE : DUMP;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_wr - CW'(rd_en);
    end
`ifdef VEC_CAPTURE_DEDUP_EN
  logic [WIDTH-1:0] last_q;
  logic last_vld;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_q <= '0;
      last_vld <= 1'b0;
    end else if (start) begin
      last_vld <= 1'b0;
    end else if (wr_en) begin
      last_q <= bus.sample_data;
      last_vld <= 1'b1;
    end
  assign dup = last_vld && bus.sample_data == last_q;
`else
  assign dup = 1'b0;
`endif
  vec_capture_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .reset_n(reset_n),
    .we(wr_en),
    .wa(wr_ptr),
    .wd(bus.sample_data),
    .ra(rd_ptr),
    .rd(bus.rd_data)
  );
  assign bus.rd_valid = state == DUMP;
  assign bus.count = count;
  assign bus.full = count == CW'(DEPTH);
  assign bus.busy = state != IDLE;
endmodule
